// File: rtl/psg_pkg.sv
// -----------------------------------------------------------------------------
// psg_pkg
// Shared constants and types for the SN76489-style PSG bus controller.
//   - channel counts and the noise channel index
//   - bit positions of the command-byte fields
//   - FSM state encoding for the write-busy handshake
//   - decoded command structure produced by psg_byte_decoder
// -----------------------------------------------------------------------------
package psg_pkg;

  localparam int NUM_TONE_CH = 3;  // tone channels 0..2
  localparam int NUM_CH      = 4;  // tone channels plus the noise channel
  localparam int NOISE_CH    = 3;  // channel index that addresses the noise register

  // Command-byte field positions
  localparam int LATCH_BIT = 7;  // 1 = latch byte, 0 = data byte
  localparam int CH_MSB    = 6;  // latch byte channel field [6:5]
  localparam int CH_LSB    = 5;
  localparam int TYPE_BIT  = 4;  // latch byte type: 1 = volume, 0 = tone/noise

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // payload carries bits 3:0 for a latch byte and bits 5:0 for a data byte
  typedef struct packed {
    logic       is_latch;
    logic [1:0] channel;
    logic       is_volume;
    logic [5:0] payload;
  } psg_cmd_t;

endpackage

// File: rtl/psg_byte_decoder.sv
// -----------------------------------------------------------------------------
// psg_byte_decoder
// Purely combinational split of an SN76489 command byte into its fields.
// Ports:
//   byte_i  in  [7:0]     raw bus byte
//   cmd_o   out psg_cmd_t {is_latch, channel, is_volume, payload}
// channel/is_volume are only meaningful for latch bytes; the controller uses
// its held latched index for data bytes.
// -----------------------------------------------------------------------------
module psg_byte_decoder
  import psg_pkg::*;
(
  input  logic [7:0] byte_i,
  output psg_cmd_t   cmd_o
);

  always_comb begin
    cmd_o.is_latch  = byte_i[LATCH_BIT];
    cmd_o.channel   = byte_i[CH_MSB:CH_LSB];
    cmd_o.is_volume = byte_i[TYPE_BIT];
    // Bit 6 of a data byte carries no information, so only bits 5:0 pass on.
    cmd_o.payload   = byte_i[LATCH_BIT] ? {2'b00, byte_i[3:0]} : byte_i[5:0];
  end

endmodule

// File: rtl/psg_bus_controller.sv
// -----------------------------------------------------------------------------
// psg_bus_controller
// Bus front-end of an SN76489-style PSG: accepts command bytes over a
// valid/ready handshake and maintains the volume, tone and noise registers.
//
// Parameters:
//   ATTENUATION_CONTROL_BITS  width of each volume register (default 4)
//   FREQUENCY_COUNTER_BITS    width of each tone register   (default 10)
//   NOISE_CONTROL_BITS        width of the noise register   (default 3)
//   BUSY_CYCLES               wr_ready low time after each accept (default 32)
// Ports:
//   clk         in   single clock
//   reset       in   synchronous, active-high reset
//   wr_valid    in   a bus byte is offered
//   wr_data     in   [7:0] command byte
//   wr_ready    out  byte accepted this cycle when wr_valid is also high
//   attn        out  4 volume registers, channel n at [n*ACB +: ACB]
//   tone_freq   out  3 tone registers, tone n at [n*FCB +: FCB]
//   noise_ctrl  out  {white/periodic, rate[1:0]}
//   reset_lfsr  out  one-cycle pulse coincident with every noise write
//
// Build option:
//   PSG_WRITE_BUSY_EN  defined   -> IDLE/BUSY handshake with busy counter
//                      undefined -> no counter, wr_ready = !reset
// -----------------------------------------------------------------------------
module psg_bus_controller
  import psg_pkg::*;
#(
  parameter int ATTENUATION_CONTROL_BITS = 4,
  parameter int FREQUENCY_COUNTER_BITS   = 10,
  parameter int NOISE_CONTROL_BITS       = 3,
  parameter int BUSY_CYCLES              = 32
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         wr_valid,
  input  logic [7:0]                                   wr_data,
  output logic                                         wr_ready,
  output logic [NUM_CH*ATTENUATION_CONTROL_BITS-1:0]   attn,
  output logic [NUM_TONE_CH*FREQUENCY_COUNTER_BITS-1:0] tone_freq,
  output logic [NOISE_CONTROL_BITS-1:0]                noise_ctrl,
  output logic                                         reset_lfsr
);

  localparam int ACB = ATTENUATION_CONTROL_BITS;
  localparam int FCB = FREQUENCY_COUNTER_BITS;
  localparam int NCB = NOISE_CONTROL_BITS;

  psg_cmd_t cmd;
  logic     accept;

  logic [1:0]     latch_ch_q, latch_ch_d;
  logic           latch_vol_q, latch_vol_d;
  logic [ACB-1:0] attn_q [NUM_CH];
  logic [ACB-1:0] attn_d [NUM_CH];
  logic [FCB-1:0] tone_q [NUM_TONE_CH];
  logic [FCB-1:0] tone_d [NUM_TONE_CH];
  logic [NCB-1:0] noise_q, noise_d;
  logic           reset_lfsr_q, reset_lfsr_d;

  logic [1:0] tgt_ch;
  logic       tgt_vol;

  psg_byte_decoder u_decoder (
    .byte_i (wr_data),
    .cmd_o  (cmd)
  );

  assign accept = wr_valid && wr_ready;

  // ---------------------------------------------------------------------------
  // Write handshake
  // ---------------------------------------------------------------------------
`ifdef PSG_WRITE_BUSY_EN
  localparam int CNT_W = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // BUSY_CYCLES = 0 keeps the FSM in IDLE for back-to-back accepts.
        if (accept && (BUSY_CYCLES != 0)) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(BUSY_CYCLES - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by reset so no byte slips in while reset is asserted; a reset during
  // BUSY drops straight back to IDLE, so ready returns the cycle after release.
  assign wr_ready = (state_q == ST_IDLE) && !reset;
`else
  logic unused_busy_cfg;
  assign unused_busy_cfg = (BUSY_CYCLES != 0);
  assign wr_ready        = !reset;
`endif

  // ---------------------------------------------------------------------------
  // Register file update
  // ---------------------------------------------------------------------------
  always_comb begin
    latch_ch_d   = latch_ch_q;
    latch_vol_d  = latch_vol_q;
    attn_d       = attn_q;
    tone_d       = tone_q;
    noise_d      = noise_q;
    reset_lfsr_d = 1'b0;

    // A latch byte retargets; a data byte reuses the held index.
    tgt_ch  = cmd.is_latch ? cmd.channel   : latch_ch_q;
    tgt_vol = cmd.is_latch ? cmd.is_volume : latch_vol_q;

    if (accept) begin
      latch_ch_d  = tgt_ch;
      latch_vol_d = tgt_vol;
      if (tgt_vol) begin
        attn_d[tgt_ch] = ACB'(cmd.payload[3:0]);
      end else if (tgt_ch == 2'(NOISE_CH)) begin
        // Pulse on every noise write, even if the value is unchanged.
        noise_d      = NCB'(cmd.payload[2:0]);
        reset_lfsr_d = 1'b1;
      end else if (cmd.is_latch) begin
        tone_d[tgt_ch][3:0] = cmd.payload[3:0];
      end else begin
        tone_d[tgt_ch][FCB-1:4] = (FCB-4)'(cmd.payload);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is a handful of flops, not a RAM, so it is
      // reset in full; attenuation resets to all ones (silent).
      latch_ch_q   <= '0;
      latch_vol_q  <= 1'b0;
      attn_q       <= '{default: '1};
      tone_q       <= '{default: '0};
      noise_q      <= '0;
      reset_lfsr_q <= 1'b0;
    end else begin
      latch_ch_q   <= latch_ch_d;
      latch_vol_q  <= latch_vol_d;
      attn_q       <= attn_d;
      tone_q       <= tone_d;
      noise_q      <= noise_d;
      reset_lfsr_q <= reset_lfsr_d;
    end
  end

  always_comb begin
    attn      = '0;
    tone_freq = '0;
    for (int n = 0; n < NUM_CH; n++)      attn[n*ACB +: ACB]      = attn_q[n];
    for (int n = 0; n < NUM_TONE_CH; n++) tone_freq[n*FCB +: FCB] = tone_q[n];
  end

  assign noise_ctrl = noise_q;
  assign reset_lfsr = reset_lfsr_q;

endmodule

// File: doc/psg_bus_controller.md
PSG_BUS_CONTROLLER -- requirements
Module: psg_bus_controller

Interface
REQ-001 SHALL have parameter ATTENUATION_CONTROL_BITS, default 4: width of each volume register.
REQ-002 SHALL have parameter FREQUENCY_COUNTER_BITS, default 10: width of each tone register.
REQ-003 SHALL have parameter NOISE_CONTROL_BITS, default 3: width of the noise register.
REQ-004 SHALL have parameter BUSY_CYCLES, default 32: number of cycles wr_ready stays low after an accepted byte.
REQ-005 SHALL have port clk  input  1: the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port wr_valid  input  1: a bus byte is offered.
REQ-008 SHALL have port wr_data  input  8: the SN76489 command byte.
REQ-009 SHALL have port wr_ready  output  1: the controller accepts a byte this cycle.
REQ-010 SHALL have port attn  output  4*ATTENUATION_CONTROL_BITS: channel n at bits [4n+3:4n], channels 0-2 tone, 3 noise.
REQ-011 SHALL have port tone_freq  output  3*FREQUENCY_COUNTER_BITS: tone n at [10n+9:10n].
REQ-012 SHALL have port noise_ctrl  output  NOISE_CONTROL_BITS: {white/periodic, rate[1:0]}.
REQ-013 SHALL have port reset_lfsr  output  1: one-cycle pulse on every noise-register write.

Function
REQ-014 Transfer SHALL occur only on a cycle where wr_valid && wr_ready; wr_data is ignored otherwise.
REQ-015 A latch byte (bit7=1) SHALL set latched index = {bits6:5 channel, bit4 type}; type 1 = volume, type 0 = tone/noise.
REQ-016 A latch byte SHALL write bits3:0 to the latched register: volume -> attn[ch]; tone -> tone_freq[ch][3:0], bits[9:4] kept; noise (ch3, type0) -> noise_ctrl = bits2:0.
REQ-017 A data byte (bit7=0) SHALL leave the latched index unchanged and write to the latched register: tone -> tone_freq[ch][9:4] = bits5:0, bits[3:0] kept; volume -> attn[ch] = bits3:0; noise -> noise_ctrl = bits2:0.
REQ-018 Bit6 of a data byte SHALL be ignored.
REQ-019 All register outputs SHALL be registered; an update SHALL be visible exactly one cycle after the accepting edge.
REQ-020 reset_lfsr SHALL be high for exactly one cycle, coincident with the noise_ctrl update, including when the value written is unchanged.
REQ-021 The FSM SHALL have states IDLE and BUSY.
REQ-022 In IDLE, wr_ready SHALL be 1; acceptance SHALL move to BUSY and load the counter with BUSY_CYCLES-1.
REQ-023 In BUSY, wr_ready SHALL be 0; the counter SHALL decrement each cycle and the FSM SHALL return to IDLE on the cycle after it reaches 0.
REQ-024 wr_ready SHALL be low for exactly BUSY_CYCLES cycles after each accept; BUSY_CYCLES=0 SHALL mean no BUSY (back-to-back accepts every cycle).
REQ-025 wr_valid held high during BUSY SHALL be accepted on the first IDLE cycle, exactly once.
REQ-026 A data byte before any latch byte SHALL target the reset latched index (tone 0).

Reset
REQ-027 While reset is high: attn all 4'b1111 (silent), tone_freq 0, noise_ctrl 0, latched index 0, reset_lfsr 0, wr_ready 0, FSM IDLE, counter 0.
REQ-028 Reset asserted during BUSY SHALL abort the busy window; wr_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-029 Macro PSG_WRITE_BUSY_EN: when defined, the BUSY behaviour of REQ-022..025 applies.
REQ-030 When PSG_WRITE_BUSY_EN is undefined, no counter SHALL be built and wr_ready SHALL be 1 whenever reset is low; register behaviour is unchanged.

Structure
REQ-031 Package psg_pkg SHALL hold channel-count constants, latch/type bit positions, the noise channel index and the FSM state typedef.
REQ-032 A combinational sub-module psg_byte_decoder SHALL decode a byte into {is_latch, channel, type, payload}.

Verification
REQ-033 Reset, then check: attn=16'hFFFF, tone_freq=0, noise_ctrl=0; wr_ready=0 during reset and 1 the cycle after.
REQ-034 Write 8'h8E then 8'h0F -> tone_freq[0]=10'h0FE; each accept is followed by 32 cycles of wr_ready=0 (macro on).
REQ-035 Write 8'hD5 -> attn[2]=4'h5; then 8'h0A -> attn[2]=4'hA with the latch still held.
REQ-036 Write 8'hE4 -> noise_ctrl=3'b100 with a one-cycle reset_lfsr pulse; writing 8'hE4 again pulses reset_lfsr again.
REQ-037 Assert reset in the 10th BUSY cycle -> outputs return to reset values; wr_ready=1 one cycle after release.
REQ-038 With the macro off, hold wr_valid for 4 cycles with bytes 8'h81, 8'h02, 8'hA3, 8'h04 -> four accepts; tone_freq[0]=10'h021, tone_freq[1]=10'h043.
